// File: rtl/fwd_scoreboard.sv
// Operand-bypass and hazard scoreboard: a DEPTH-stage tag pipeline chooses a forwarding source per operand and stalls until that producer is ready.
// Optional feature: define FWD_STALL_CNT_EN to build the saturating stall-cycle counter behind o_stall_cnt.
module fwd_scoreboard #(
    parameter int NSRC  = 2,
    parameter int DEPTH = 2,
    parameter int RW    = 5,
    parameter int SELW  = $clog2(DEPTH + 1)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_ex_valid,
    input  logic [RW-1:0]        i_ex_rd,
    input  logic                 i_ex_we,
    input  logic [2:0]           i_ex_lat,
    input  logic [NSRC*RW-1:0]   i_ex_rs,
    input  logic [NSRC-1:0]      i_ex_rs_used,
    input  logic                 i_flush,
    output logic [NSRC*SELW-1:0] o_fwd_sel,
    output logic                 o_stall,
    output logic [31:0]          o_stall_cnt
);

    generate
        if (DEPTH < 2 || DEPTH > 7 || NSRC < 1 || NSRC > 4) begin : g_badParam
            $error("fwd_scoreboard: DEPTH must be 2..7 and NSRC 1..4");
        end
    endgenerate

    logic [DEPTH:1]      r_tagValid;
    logic [RW-1:0]       r_tagRd  [1:DEPTH];
    logic [2:0]          r_tagLat [1:DEPTH];

    logic [2:0]          w_latNorm;
    logic [NSRC*SELW-1:0] w_fwdSel;
    logic [NSRC-1:0]     w_opWait;
    logic                w_hazard;
    logic                w_stall;
    logic                w_accept;

    always_comb begin
        w_latNorm = i_ex_lat;
        if (i_ex_lat == 3'd0) begin
            w_latNorm = 3'd1;
        end else if (int'(i_ex_lat) > DEPTH) begin
            w_latNorm = 3'(DEPTH);
        end
    end

    // Scan oldest to youngest so the youngest match overwrites, ready or not.
    always_comb begin
        w_fwdSel = '0;
        w_opWait = '0;
        for (int i = 0; i < NSRC; i++) begin
            for (int s = DEPTH; s >= 1; s--) begin
                if (i_ex_rs_used[i] && r_tagValid[s] && (r_tagRd[s] != '0) &&
                    (r_tagRd[s] == i_ex_rs[i*RW +: RW])) begin
                    w_fwdSel[i*SELW +: SELW] = SELW'(s);
                    w_opWait[i]              = (s < int'(r_tagLat[s]));
                end
            end
        end
    end

    assign w_hazard  = i_ex_valid & (|w_opWait);
    assign w_stall   = w_hazard & ~i_flush;
    assign w_accept  = i_ex_valid & i_ex_we & ~i_flush & ~w_stall;

    assign o_fwd_sel = w_fwdSel;
    assign o_stall   = w_stall;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_tagValid <= '0;
            for (int s = 1; s <= DEPTH; s++) begin
                r_tagRd[s]  <= '0;
                r_tagLat[s] <= 3'd1;
            end
        end else begin
            for (int s = DEPTH; s >= 2; s--) begin
                r_tagValid[s] <= r_tagValid[s-1];
                r_tagRd[s]    <= r_tagRd[s-1];
                r_tagLat[s]   <= r_tagLat[s-1];
            end
            r_tagValid[1] <= w_accept;
            r_tagRd[1]    <= i_ex_rd;
            r_tagLat[1]   <= w_latNorm;
        end
    end

`ifdef FWD_STALL_CNT_EN
    logic [31:0] r_stallCnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_stallCnt <= '0;
        end else if (w_stall && (r_stallCnt != 32'hFFFF_FFFF)) begin
            r_stallCnt <= r_stallCnt + 32'd1;
        end
    end

    assign o_stall_cnt = r_stallCnt;
`else
    assign o_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Bench for fwd_scoreboard: directed scenarios then random traffic, checked against a timestamped producer-list model.
module tb_fwd_scoreboard;

    localparam int NSRC  = 2;
    localparam int DEPTH = 2;
    localparam int RW    = 5;
    localparam int SELW  = 2;

    logic                 clk;
    logic                 rstN;
    logic                 exValid;
    logic [RW-1:0]        exRd;
    logic                 exWe;
    logic [2:0]           exLat;
    logic [NSRC*RW-1:0]   exRs;
    logic [NSRC-1:0]      exRsUsed;
    logic                 flush;
    logic [NSRC*SELW-1:0] fwdSel;
    logic                 stall;
    logic [31:0]          stallCnt;

    fwd_scoreboard #(.NSRC(NSRC), .DEPTH(DEPTH), .RW(RW), .SELW(SELW)) dut (
        .i_clk(clk), .i_rst_n(rstN), .i_ex_valid(exValid), .i_ex_rd(exRd),
        .i_ex_we(exWe), .i_ex_lat(exLat), .i_ex_rs(exRs), .i_ex_rs_used(exRsUsed),
        .i_flush(flush), .o_fwd_sel(fwdSel), .o_stall(stall), .o_stall_cnt(stallCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each producer remembers the cycle it was accepted; its stage is its age.
    typedef struct {
        logic [RW-1:0] rd;
        int            lat;
        int            born;
    } prod_t;

    prod_t       prodQ[$];
    int          cyc = 0;
    logic [31:0] mCnt = 0;
    int          expSel [NSRC];
    bit          expStall;
    int          compareCount = 0;
    int          failCount = 0;

    function automatic void predict();
        bit hazard = 0;
        for (int i = 0; i < NSRC; i++) begin
            int  best = 0;
            bit  bestReady = 1;
            logic [RW-1:0] rs = exRs[i*RW +: RW];
            foreach (prodQ[k]) begin
                int st = cyc - prodQ[k].born + 1;
                if (exRsUsed[i] && st <= DEPTH && prodQ[k].rd != 0 && prodQ[k].rd == rs &&
                    (best == 0 || st < best)) begin
                    best      = st;
                    bestReady = (st >= prodQ[k].lat);
                end
            end
            expSel[i] = best;
            if (best != 0 && !bestReady) hazard = 1;
        end
        expStall = exValid && hazard && !flush;
    endfunction

    task automatic tick();
        @(posedge clk);
        predict();
        if (!rstN) begin
            prodQ.delete();
            mCnt = 0;
        end else begin
            prod_t keep[$];
            if (expStall && mCnt != 32'hFFFF_FFFF) mCnt = mCnt + 1;
            cyc++;
            foreach (prodQ[k]) if (cyc - prodQ[k].born + 1 <= DEPTH) keep.push_back(prodQ[k]);
            if (exValid && exWe && !flush && !expStall) begin
                prod_t p;
                p.rd   = exRd;
                p.lat  = (exLat == 0) ? 1 : ((int'(exLat) > DEPTH) ? DEPTH : int'(exLat));
                p.born = cyc;
                keep.push_back(p);
            end
            prodQ = keep;
        end
        #1;
    endtask

    task automatic applyStimulus(input bit v, input logic [RW-1:0] rd, input bit we,
                                 input logic [2:0] lat, input logic [RW-1:0] rs0,
                                 input logic [RW-1:0] rs1, input logic [1:0] used, input bit fl);
        exValid  = v;
        exRd     = rd;
        exWe     = we;
        exLat    = lat;
        exRs     = {rs1, rs0};
        exRsUsed = used;
        flush    = fl;
        #1;
    endtask

    task automatic checkOutput(input string tag);
        logic [31:0] expCnt;
        predict();
`ifdef FWD_STALL_CNT_EN
        expCnt = mCnt;
`else
        expCnt = 32'd0;
`endif
        for (int i = 0; i < NSRC; i++) begin
            compareCount++;
            assert (fwdSel[i*SELW +: SELW] === SELW'(expSel[i])) else begin
                failCount++;
                $error("[TB] FAIL %s fwd_sel[%0d]: observed %0d expected %0d", tag, i,
                       fwdSel[i*SELW +: SELW], expSel[i]);
            end
        end
        compareCount++;
        assert (stall === expStall) else begin
            failCount++;
            $error("[TB] FAIL %s stall: observed %b expected %b", tag, stall, expStall);
        end
        compareCount++;
        assert (stallCnt === expCnt) else begin
            failCount++;
            $error("[TB] FAIL %s stall_cnt: observed %0d expected %0d", tag, stallCnt, expCnt);
        end
    endtask

    initial begin
        rstN = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 2'b00, 0);
        tick();
        tick();
        rstN = 1'b1;
        checkOutput("reset");

        // ALU back-to-back
        applyStimulus(1, 5, 1, 1, 0, 0, 2'b00, 0);
        checkOutput("alu_i1");
        tick();
        applyStimulus(1, 6, 0, 1, 5, 0, 2'b01, 0);
        checkOutput("alu_i2");
        compareCount++;
        assert (fwdSel[SELW-1:0] === 2'd1 && stall === 1'b0) else begin
            failCount++;
            $error("[TB] FAIL alu_direct: observed sel %0d stall %b expected sel 1 stall 0",
                   fwdSel[SELW-1:0], stall);
        end
        tick();

        // Load-use: one stall then forward from stage 2
        applyStimulus(1, 7, 1, 2, 0, 0, 2'b00, 0);
        checkOutput("lu_i1");
        tick();
        applyStimulus(1, 8, 0, 1, 1, 7, 2'b10, 0);
        checkOutput("lu_stall");
        compareCount++;
        assert (stall === 1'b1 && fwdSel[2*SELW-1:SELW] === 2'd1) else begin
            failCount++;
            $error("[TB] FAIL lu_direct: observed stall %b sel %0d expected stall 1 sel 1",
                   stall, fwdSel[2*SELW-1:SELW]);
        end
        tick();
        checkOutput("lu_release");
        tick();

        // Double producer of x3
        applyStimulus(1, 3, 1, 1, 0, 0, 2'b00, 0);
        tick();
        applyStimulus(1, 3, 1, 1, 0, 0, 2'b00, 0);
        tick();
        applyStimulus(1, 0, 0, 1, 3, 3, 2'b11, 0);
        checkOutput("double");

        // x0 never matches; unused operand ignored
        tick();
        applyStimulus(1, 0, 1, 2, 0, 0, 2'b00, 0);
        tick();
        applyStimulus(1, 9, 1, 2, 0, 0, 2'b01, 0);
        checkOutput("x0");
        tick();
        applyStimulus(1, 0, 0, 1, 4, 9, 2'b01, 0);
        checkOutput("unused");
        tick();

        // Flush during hazard
        applyStimulus(1, 12, 1, 3, 0, 0, 2'b00, 0);
        tick();
        applyStimulus(1, 13, 1, 1, 12, 0, 2'b01, 1);
        checkOutput("flush_hazard");
        tick();
        applyStimulus(1, 0, 0, 1, 13, 0, 2'b01, 0);
        checkOutput("flush_bubble");
        tick();

        // Reset while stalled
        applyStimulus(1, 14, 1, 2, 0, 0, 2'b00, 0);
        tick();
        applyStimulus(1, 0, 0, 1, 14, 0, 2'b01, 0);
        checkOutput("rst_pre");
        rstN = 1'b0;
        tick();
        rstN = 1'b1;
        checkOutput("rst_post");
        tick();

        // Random traffic; a stalled instruction re-presents its inputs
        for (int n = 0; n < 400; n++) begin
            if (!expStall) begin
                applyStimulus(($urandom_range(0, 7) != 0), RW'($urandom_range(0, 7)),
                              ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                              RW'($urandom_range(0, 7)), RW'($urandom_range(0, 7)),
                              2'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0));
            end else begin
                flush = ($urandom_range(0, 7) == 0);
                #1;
            end
            rstN = ($urandom_range(0, 63) != 0);
            checkOutput("random");
            tick();
            rstN = 1'b1;
            predict();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule

// File: doc/fwd_scoreboard.md
# fwd_scoreboard

Parametrised operand-bypass and hazard block for the RV64I pipeline, the generalised successor to the fixed two-stage forwarding unit. It keeps its own shift pipeline of in-flight destination tags (DEPTH stages beyond EX) and their result latencies. For each of NSRC source operands of the instruction in EX it selects the youngest valid producer, or the register file. When the youngest matching producer has not yet produced its result (load-use or multi-cycle), it raises `stall` and inserts a bubble into its tag pipeline.

## Interface
- `NSRC`, 2, source operands checked per instruction (1..4).
- `DEPTH`, 2, tracked producer stages after EX (stage 1 = EX/MEM … stage DEPTH = oldest); range 2..7.
- `RW`, 5, register index width.
- `SELW`, $clog2(DEPTH+1), derived; width of one select field.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `ex_valid`  in  1  instruction in EX is valid.
- `ex_rd`  in  RW  destination of the EX instruction.
- `ex_we`  in  1  EX instruction writes `ex_rd`.
- `ex_lat`  in  3  stage at which the EX result becomes forwardable (1 = ALU, 2 = load, …).
- `ex_rs`  in  NSRC*RW  source indices; operand i in bits [i*RW +: RW].
- `ex_rs_used`  in  NSRC  operand i is actually read.
- `flush`  in  1  kill the EX instruction this cycle.
- `fwd_sel`  out  NSRC*SELW  per operand: 0 = register file, s = stage s.
- `stall`  out  1  hold IF/ID/EX; the EX instruction must not advance.
- `stall_cnt`  out  32  stall-cycle counter (see Configuration).

## Operation
- Tag pipeline entry per stage s: `v`, `rd`, `lat`. Entry is *ready* when s ≥ lat.
- Match for operand i at stage s: `ex_rs_used[i]`, `v[s]`, `rd[s] != 0`, `rd[s] == rs_i`. Entries with `ex_we`=0 are stored with `v`=0.
- `fwd_sel[i]` = smallest matching s (youngest); 0 if no match. Older matches are ignored once a younger one exists, including an unready younger one.
- `hazard` = `ex_valid` & any operand whose youngest match is not ready.
- `stall` = `hazard` & !`flush`.
- `ex_lat` normalisation before storing: 0 → 1, > DEPTH → DEPTH.
- Shift on every cycle, no global hold: stage s+1 ← stage s for s = 1..DEPTH-1; stage DEPTH is discarded.
- Stage 1 load:
  - gets {`ex_valid` & `ex_we` & !`flush` & !`stall`, `ex_rd`, normalised `ex_lat`};
  - otherwise it gets a bubble (`v`=0).
- A stalled instruction re-presents the same inputs next cycle. Its producer moves one stage older and becomes ready after at most DEPTH-1 stall cycles.
- Combinational outputs: `fwd_sel` and `stall` depend on current registered state plus the current `ex_*` inputs; no internal feedback from `stall` into `fwd_sel`.
- `rd` = x0 never forwards and never stalls.

## Timing
- Reset (`rst_n`=0 at a rising edge): all `v` ← 0, `stall_cnt` ← 0. Consequently `fwd_sel` = 0 and `stall` = 0 on the cycle after reset.
- Reset mid-operation drops all tracked producers; no stall carries across reset.
- Forward latency: a producer accepted at edge N is visible at stage 1 in cycle N+1, stage s in cycle N+s.
- Load-use with DEPTH=2 and `ex_lat`=2: exactly 1 stall cycle, then `fwd_sel`=2.
- Simultaneous `flush` and `hazard`: `stall`=0, bubble inserted, no stall counted.
- Simultaneous matches in several stages: the youngest wins, whether or not it is ready.
- `ex_valid`=0: `stall`=0, bubble inserted; `fwd_sel` is still computed, and the consumer ignores it.

## Configuration
- `FWD_STALL_CNT_EN` defined: `stall_cnt` increments by 1 on every rising edge where `stall`=1 and saturates at 32'hFFFF_FFFF; cleared only by reset.
- Not defined: no counter register; `stall_cnt` is tied to 32'd0.

## Test plan
- ALU back-to-back (DEPTH=2): I1 writes x5, `ex_lat`=1; next cycle I2 reads x5 in rs1 → `fwd_sel[0]`=1, `stall`=0.
- Load-use: I1 writes x7 with `ex_lat`=2; I2 reads x7 in rs2 → cycle 1: `stall`=1, `fwd_sel[1]`=1; cycle 2: `stall`=0, `fwd_sel[1]`=2; with the macro, `stall_cnt`=1.
- Double producer: x3 written at stage 1 and stage 2 (both ready), I3 reads x3 on both operands → `fwd_sel` = {1,1}.
- x0 and unused operands: stage 1 holds rd=0, and rs1=0, rs2 matches stage 1 with `ex_rs_used`=2'b01 → `fwd_sel`=0, `stall`=0.
- Flush during hazard: load-use condition plus `flush`=1 → `stall`=0, and next cycle stage 1 `v`=0; `stall_cnt` is unchanged.
- Reset mid-stall: `rst_n`=0 for one edge while `stall`=1 → next cycle `stall`=0, `fwd_sel`=0, `stall_cnt`=0.
